// File: rtl/uart_tx_param_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_param_if : valid/ready word handshake feeding uart_tx_param.  rev 1.0
// ----------------------------------------------------------------------------
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_param : parametrised UART transmitter, one-word holding buffer,
// optional parity bit when UART_TX_PARITY_EN is defined.              rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int STOP_BITS  = 1
) (
  input  wire             clk,
  input  wire             rst,
  input  wire             clk_en,
  input  wire             parity_odd,
  uart_tx_param_if.slave  tx_if,
  output logic            tx,
  output logic            busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                 state, state_n;
  logic [TW-1:0]          tick, tick_n;
  logic [BW-1:0]          bit_cnt, bit_n;
  logic                   stop_cnt, stop_n;
  logic [DATA_BITS-1:0]   shifter, shifter_n;
  logic [DATA_BITS-1:0]   buf_data, buf_n;
  logic                   buf_full, full_n;
  logic                   tx_n;
  logic                   load;
  logic                   bit_end;

`ifdef UART_TX_PARITY_EN
  logic                   par_bit, par_n;
`else
  logic                   unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign bit_end        = (tick == TICK_LAST);
  assign tx_if.tx_ready = ~buf_full;
  assign busy           = (state != IDLE) | buf_full;

  always_comb begin
    state_n   = state;
    tick_n    = tick;
    bit_n     = bit_cnt;
    stop_n    = stop_cnt;
    shifter_n = shifter;
    buf_n     = buf_data;
    full_n    = buf_full;
    tx_n      = tx;
    load      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n     = par_bit;
`endif

    // Acceptance only when empty, so it can never collide with a drain below.
    if (tx_if.tx_valid && !buf_full) begin
      full_n = 1'b1;
      buf_n  = tx_if.tx_data;
    end

    if (clk_en) begin
      tick_n = bit_end ? '0 : tick + 1'b1;
      unique case (state)
        IDLE: begin
          tick_n = '0;
          if (buf_full) load = 1'b1;
        end
        START: begin
          if (bit_end) begin
            state_n = DATA;
            bit_n   = '0;
            tx_n    = shifter[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_n = PARITY;
              tx_n    = par_bit;
`else
              state_n = STOP;
              stop_n  = 1'b0;
              tx_n    = 1'b1;
`endif
            end else begin
              bit_n     = bit_cnt + 1'b1;
              shifter_n = shifter >> 1;
              tx_n      = shifter_n[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_n = STOP;
            stop_n  = 1'b0;
            tx_n    = 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              // Back-to-back: a held word starts straight from the last stop tick.
              if (buf_full) begin
                load = 1'b1;
              end else begin
                state_n = IDLE;
                tx_n    = 1'b1;
              end
            end else begin
              stop_n = stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      endcase

      if (load) begin
        state_n   = START;
        tick_n    = '0;
        shifter_n = buf_data;
        full_n    = 1'b0;
        tx_n      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n     = (^buf_data) ^ parity_odd;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shifter  <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tick     <= tick_n;
      bit_cnt  <= bit_n;
      stop_cnt <= stop_n;
      shifter  <= shifter_n;
      buf_data <= buf_n;
      buf_full <= full_n;
      tx       <= tx_n;
`ifdef UART_TX_PARITY_EN
      par_bit  <= par_n;
`endif
    end
  end

endmodule
`default_nettype wire
